// File: rtl/and_mux_gate_skid_pkg.sv
// Shared types and default sizes for the and_mux sequential fixtures.
package and_mux_gate_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/and_mux_gate_bit.sv
// Single-bit zero gate: passes x when s is high, otherwise drives 0.
module and_mux_gate_bit (
    input  logic s,
    input  logic x,
    output logic y
);

    assign y = s ? x : 1'b0;

endmodule

// File: rtl/and_mux_gate_skid.sv
// Two-entry valid/ready skid buffer with zero-gated output data and a delivered-beat counter.
//   state | meaning
//   EMPTY | no beat buffered, m_data forced to zero
//   ONE   | main_q holds the oldest beat
//   FULL  | main_q oldest, skid_q younger; upstream stalled
module and_mux_gate_skid
    import and_mux_gate_skid_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] beat_count
);

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] main_next;
    logic             push;
    logic             pop;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    assign s_ready = (state_q != FULL);
    assign m_valid = (state_q != EMPTY);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        load_main = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_main = 1'b1;
                    end else if (push) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign main_next = main_from_skid ? skid_q : s_data;

    // Data registers: enables only, so no extra gating structure appears on the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= main_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= s_data;
        end
    end

    // A handshake in the flush cycle still counts as delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
        end else if (pop) begin
            beat_count <= beat_count + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_gate
        and_mux_gate_bit u_gate (
            .s (m_valid),
            .x (main_q[i]),
            .y (m_data[i])
        );
    end

endmodule

// File: tb/tb_and_mux_gate_skid.sv
// Directed self-checking bench for the zero-gated skid buffer.
module tb_and_mux_gate_skid;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [7:0] beat_count;

    int checks;
    int errors;

    and_mux_gate_skid #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hFF;
        m_ready = 1'b0;
        step();
        step();
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++;
        if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
        checks++;
        if (beat_count !== 8'd0) begin errors++; $display("FAIL reset_beat_count: got %0d expected 0", beat_count); end
        s_valid = 1'b0;
        rst_n   = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        logic [7:0] vec [3];
        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = vec[i];
            step();
            checks++;
            if (m_valid !== 1'b1 || m_data !== vec[i]) begin
                errors++;
                $display("FAIL stream_data[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, m_valid, m_data, vec[i]);
            end
            checks++;
            if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_s_ready[%0d]: got %b expected 1", i, s_ready); end
        end
        s_valid = 1'b0;
        step();
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL stream_drain: got valid=%b data=%h expected valid=0 data=00", m_valid, m_data);
        end
        checks++;
        if (beat_count !== 8'd3) begin errors++; $display("FAIL stream_count: got %0d expected 3", beat_count); end
        m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        step();
        checks++;
        if (m_data !== 8'hA5 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_one: got data=%h s_ready=%b expected data=a5 s_ready=1", m_data, s_ready);
        end
        s_data = 8'h5A;
        step();
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'hA5) begin
            errors++;
            $display("FAIL bp_full: got s_ready=%b valid=%b data=%h expected s_ready=0 valid=1 data=a5", s_ready, m_valid, m_data);
        end
        s_valid = 1'b0;
        s_data  = 8'hEE;
        m_ready = 1'b1;
        step();
        checks++;
        if (s_ready !== 1'b1 || m_data !== 8'h5A) begin
            errors++;
            $display("FAIL bp_second: got s_ready=%b data=%h expected s_ready=1 data=5a", s_ready, m_data);
        end
        step();
        checks++;
        if (m_valid !== 1'b0 || beat_count !== 8'd5) begin
            errors++;
            $display("FAIL bp_drain: got valid=%b count=%0d expected valid=0 count=5", m_valid, beat_count);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h77;
        step();
        s_data = 8'h88;
        step();
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 8'h00 || beat_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: got s_ready=%b valid=%b data=%h count=%0d expected 1 0 00 0", s_ready, m_valid, m_data, beat_count);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_counter_wrap();
        m_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            step();
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'(i) || s_ready !== 1'b1 || beat_count !== 8'(i)) begin
                errors++;
                $display("FAIL wrap_beat[%0d]: got valid=%b data=%h s_ready=%b count=%0d expected 1 %h 1 %0d",
                         i, m_valid, m_data, s_ready, beat_count, 8'(i), i);
            end
        end
        s_valid = 1'b0;
        step();
        checks++;
        if (beat_count !== 8'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_count: got count=%0d valid=%b expected count=0 valid=0", beat_count, m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        step();
        s_data = 8'hC3;
        step();
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL flush_setup: got s_ready=%b expected 0", s_ready); end
        s_valid = 1'b0;
        flush   = 1'b1;
        m_ready = 1'b1;
        step();
        flush   = 1'b0;
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got valid=%b data=%h s_ready=%b expected 0 00 1", m_valid, m_data, s_ready);
        end
        checks++;
        if (beat_count !== 8'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", beat_count); end
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h99;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL flush_push_drop: got valid=%b data=%h expected 0 00", m_valid, m_data);
        end
        s_valid = 1'b1;
        s_data  = 8'h4B;
        step();
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h4B) begin
            errors++;
            $display("FAIL flush_recover: got valid=%b data=%h expected 1 4b", m_valid, m_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
